// File: rtl/uart_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_loader
// Purpose  : Serial boot engine. It polls the UART register interface, takes
//            one framed download (sync, addr, len, data, chk), writes the data
//            to memory and answers with ACK/NAK. Define LOADER_TIMEOUT_EN to add
//            an inter-byte timeout.
// Revision : 1.0 - initial release
// ============================================================================
module uart_loader #(
    parameter logic [7:0]  SYNC_BYTE      = 8'h55,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15,
    parameter int unsigned TIMEOUT_CYCLES = 3200000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  u_dout,
    output logic [7:0]  u_din,
    output logic        u_a0,
    output logic        u_rnw,
    output logic        u_cs_b,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [2:0] c_S_IDLE     = 3'd0;
    localparam logic [2:0] c_S_POLL_RX  = 3'd1;
    localparam logic [2:0] c_S_READ_RX  = 3'd2;
    localparam logic [2:0] c_S_PARSE    = 3'd3;
    localparam logic [2:0] c_S_POLL_TX  = 3'd4;
    localparam logic [2:0] c_S_WRITE_TX = 3'd5;
    localparam logic [2:0] c_S_FINISH   = 3'd6;

    localparam logic [2:0] c_F_SYNC = 3'd0;
    localparam logic [2:0] c_F_AH   = 3'd1;
    localparam logic [2:0] c_F_AL   = 3'd2;
    localparam logic [2:0] c_F_LEN  = 3'd3;
    localparam logic [2:0] c_F_DATA = 3'd4;
    localparam logic [2:0] c_F_CHK  = 3'd5;

    logic [2:0]  r_state;
    logic [2:0]  r_field;
    logic [7:0]  r_byte;
    logic [7:0]  r_addr_hi;
    logic [15:0] r_addr;
    logic [8:0]  r_remain;
    logic [7:0]  r_sum;
    logic [7:0]  r_reply;
    logic        r_error;
    logic        r_last_acc;

    logic        w_want;
    logic        w_acc;
    logic        w_write;
    logic        w_tmo_hit;
    logic [7:0]  w_sum_next;

    always_comb begin
        w_want = 1'b0;
        case (r_state)
            c_S_POLL_RX, c_S_READ_RX, c_S_POLL_TX, c_S_WRITE_TX: w_want = 1'b1;
            default: w_want = 1'b0;
        endcase
    end

    // An access is granted only if the previous cycle was idle on the bus, so
    // chip select never stays low across two cycles; reset kills it at once.
    assign w_acc   = w_want && !r_last_acc && !reset;
    assign w_write = w_acc && (r_state == c_S_WRITE_TX);

    assign u_cs_b     = !w_acc;
    assign u_rnw      = !w_write;
    assign u_a0       = w_acc && ((r_state == c_S_READ_RX) || (r_state == c_S_WRITE_TX));
    assign u_din      = w_write ? r_reply : 8'h00;
    assign mem_we     = (r_state == c_S_PARSE) && (r_field == c_F_DATA) && !reset;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_byte;
    assign busy       = (r_state != c_S_IDLE) && (r_state != c_S_FINISH);
    assign done       = (r_state == c_S_FINISH);
    assign error      = r_error;
    assign w_sum_next = r_sum + r_byte;

`ifdef LOADER_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

    logic [c_TMO_W-1:0] r_tmo;

    // Counts only while a frame is in progress; hunting for SYNC never times out.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo <= '0;
        end else if ((r_state == c_S_READ_RX) || (r_state == c_S_IDLE)) begin
            r_tmo <= '0;
        end else if ((r_state == c_S_POLL_RX) && (r_field != c_F_SYNC) &&
                     (r_tmo != c_TMO_LAST)) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    assign w_tmo_hit = (r_state == c_S_POLL_RX) && (r_field != c_F_SYNC) &&
                       (r_tmo == c_TMO_LAST);
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_S_IDLE;
            r_field    <= c_F_SYNC;
            r_byte     <= 8'h00;
            r_addr_hi  <= 8'h00;
            r_addr     <= 16'h0000;
            r_remain   <= 9'd0;
            r_sum      <= 8'h00;
            r_reply    <= 8'h00;
            r_error    <= 1'b0;
            r_last_acc <= 1'b0;
        end else begin
            r_last_acc <= w_acc;
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_state <= c_S_POLL_RX;
                        r_field <= c_F_SYNC;
                        r_sum   <= 8'h00;
                        r_error <= 1'b0;
                    end
                end
                c_S_POLL_RX: begin
                    if (w_acc && u_dout[6]) begin
                        r_state <= c_S_READ_RX;
                    end else if (w_tmo_hit) begin
                        r_reply <= NAK_BYTE;
                        r_error <= 1'b1;
                        r_state <= c_S_POLL_TX;
                    end
                end
                c_S_READ_RX: begin
                    if (w_acc) begin
                        r_byte  <= u_dout;
                        r_state <= c_S_PARSE;
                    end
                end
                c_S_PARSE: begin
                    r_state <= c_S_POLL_RX;
                    case (r_field)
                        c_F_SYNC: begin
                            if (r_byte == SYNC_BYTE) r_field <= c_F_AH;
                        end
                        c_F_AH: begin
                            r_addr_hi <= r_byte;
                            r_sum     <= w_sum_next;
                            r_field   <= c_F_AL;
                        end
                        c_F_AL: begin
                            r_addr  <= {r_addr_hi, r_byte};
                            r_sum   <= w_sum_next;
                            r_field <= c_F_LEN;
                        end
                        c_F_LEN: begin
                            r_remain <= (r_byte == 8'h00) ? 9'd256 : {1'b0, r_byte};
                            r_sum    <= w_sum_next;
                            r_field  <= c_F_DATA;
                        end
                        c_F_DATA: begin
                            // mem_we is high this cycle; advance to the next address
                            r_addr   <= r_addr + 16'd1;
                            r_sum    <= w_sum_next;
                            r_remain <= r_remain - 9'd1;
                            if (r_remain == 9'd1) r_field <= c_F_CHK;
                        end
                        c_F_CHK: begin
                            if (w_sum_next == 8'h00) begin
                                r_reply <= ACK_BYTE;
                            end else begin
                                r_reply <= NAK_BYTE;
                                r_error <= 1'b1;
                            end
                            r_state <= c_S_POLL_TX;
                        end
                        default: r_field <= c_F_SYNC;
                    endcase
                end
                c_S_POLL_TX: begin
                    if (w_acc && !u_dout[7]) r_state <= c_S_WRITE_TX;
                end
                c_S_WRITE_TX: begin
                    if (w_acc) r_state <= c_S_FINISH;
                end
                c_S_FINISH: r_state <= c_S_IDLE;
                default:    r_state <= c_S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_loader
// Purpose  : Self-checking bench for uart_loader with a UART/memory model and
//            a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_loader;

    typedef logic [7:0] bq_t [$];

    typedef struct {
        string         name;
        int            n;
        logic [95:0]   bytes;   // byte k of the stream sits at bits [8k+7:8k]
        int            hold;
        logic [7:0]    reply;
        logic          err;
        int            nwr;
        logic [23:0]   first_wr;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  u_dout;
    logic [7:0]  u_din;
    logic        u_a0;
    logic        u_rnw;
    logic        u_cs_b;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        busy;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    uart_loader #(.TIMEOUT_CYCLES(100)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .u_dout    (u_dout),
        .u_din     (u_din),
        .u_a0      (u_a0),
        .u_rnw     (u_rnw),
        .u_cs_b    (u_cs_b),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    // UART register model and memory capture
    logic [7:0]  rx_q [$];
    logic        rx_full;
    logic        tx_busy;
    logic [7:0]  rx_data;
    int          gap = 0, gap_cfg = 0, hold = 0, hold_cfg = 0;
    logic [23:0] wr_log [$];
    logic [7:0]  tx_log [$];
    int          proto_err = 0, reset_leak = 0, busy_polls = 0;
    int          cyc = 0, last_rd_cyc = 0;
    logic        prev_cs_low = 1'b0;

    assign u_dout = u_a0 ? rx_data : {tx_busy, rx_full, 6'b000000};

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            if (!u_cs_b || mem_we) reset_leak++;
            rx_full <= 1'b0;
            tx_busy <= 1'b0;
            rx_data <= 8'h00;
            rx_q.delete();
            gap = 0;
            hold = 0;
            prev_cs_low = 1'b0;
        end else begin
            if (!u_cs_b && prev_cs_low) proto_err++;
            prev_cs_low = !u_cs_b;
            if (mem_we) wr_log.push_back({mem_addr, mem_wdata});
            if (!u_cs_b && !u_rnw) begin
                tx_log.push_back(u_din);
                if (!u_a0 || tx_busy) proto_err++;
            end
            if (!u_cs_b && u_rnw && !u_a0 && tx_busy) busy_polls++;
            if (hold > 0) begin
                hold--;
                if (hold == 0) tx_busy <= 1'b0;
            end
            if (!u_cs_b && u_rnw && u_a0) begin
                if (!rx_full) proto_err++;
                rx_full <= 1'b0;
                gap = gap_cfg;
                last_rd_cyc = cyc;
                if (rx_q.size() == 0 && hold_cfg > 0) begin
                    tx_busy <= 1'b1;
                    hold = hold_cfg;
                end
            end else if (!rx_full && rx_q.size() > 0) begin
                if (gap > 0) gap--;
                else begin
                    rx_data <= rx_q.pop_front();
                    rx_full <= 1'b1;
                end
            end
        end
    end

    // Reference model: derives the memory writes and reply from the byte stream
    logic [23:0] exp_wr [$];
    logic [7:0]  exp_reply;
    logic        exp_err;

    function automatic void ref_frame(input bq_t b);
        int i, n;
        int unsigned base, s;
        exp_wr.delete();
        i = 0;
        while (i < b.size() && b[i] != 8'h55) i++;
        base = {16'h0000, b[i+1], b[i+2]};
        n = (b[i+3] == 8'h00) ? 256 : int'(b[i+3]);
        s = int'(b[i+1]) + int'(b[i+2]) + int'(b[i+3]);
        for (int k = 0; k < n; k++) begin
            exp_wr.push_back({16'((base + k) % 65536), b[i+4+k]});
            s += int'(b[i+4+k]);
        end
        s += int'(b[i+4+n]);
        exp_err   = (s % 256) != 0;
        exp_reply = exp_err ? 8'h15 : 8'h06;
    endfunction

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_frame(input string name, input bq_t b, input int hold_c, input int gap_c);
        int   w0, t0, p0, bp0, nbad;
        logic got_done;
        ref_frame(b);
        w0 = wr_log.size(); t0 = tx_log.size(); p0 = proto_err; bp0 = busy_polls;
        hold_cfg = hold_c;
        gap_cfg  = gap_c;
        foreach (b[k]) rx_q.push_back(b[k]);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk({name, " busy after start"}, 32'(busy), 32'd1);
        chk({name, " error cleared"}, 32'(error), 32'd0);
        got_done = 1'b0;
        for (int w = 0; w < 20000 && !got_done; w++) begin
            @(negedge clk);
            got_done = done;
        end
        chk({name, " done seen"}, 32'(got_done), 32'd1);
        chk({name, " write count"}, wr_log.size() - w0, exp_wr.size());
        nbad = 0;
        for (int k = 0; k < exp_wr.size(); k++)
            if (w0 + k >= wr_log.size() || wr_log[w0+k] !== exp_wr[k]) nbad++;
        chk({name, " write contents"}, nbad, 0);
        chk({name, " reply count"}, tx_log.size() - t0, 1);
        chk({name, " reply byte"}, 32'(tx_log[t0]), 32'(exp_reply));
        chk({name, " error flag"}, 32'(error), 32'(exp_err));
        chk({name, " bus protocol"}, proto_err - p0, 0);
        if (hold_c > 0) chk({name, " polled while tx busy"}, 32'(busy_polls > bp0), 32'd1);
        @(negedge clk);
        chk({name, " done one cycle"}, 32'(done), 32'd0);
        chk({name, " idle busy"}, 32'(busy), 32'd0);
        chk({name, " error held"}, 32'(error), 32'(exp_err));
    endtask

    vec_t        tbl [4];
    bq_t         q;
    int          w0, t0, ws;
    logic [7:0]  v, ah, al, len, c;
    int unsigned s;

    initial begin
        tbl[0] = '{"good", 7, {8'h53, 8'hBB, 8'hAA, 8'h02, 8'h34, 8'h12, 8'h55},
                   0, 8'h06, 1'b0, 2, 24'h1234AA};
        tbl[1] = '{"badchk", 7, {8'h54, 8'hBB, 8'hAA, 8'h02, 8'h34, 8'h12, 8'h55},
                   0, 8'h15, 1'b1, 2, 24'h1234AA};
        tbl[2] = '{"noise", 9, {8'h42, 8'h77, 8'h01, 8'h34, 8'h12, 8'h55, 8'h13, 8'hFF, 8'h00},
                   0, 8'h06, 1'b0, 1, 24'h123477};
        tbl[3] = '{"backpressure", 7, {8'h53, 8'hBB, 8'hAA, 8'h02, 8'h34, 8'h12, 8'h55},
                   50, 8'h06, 1'b0, 2, 24'h1234AA};

        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset u_cs_b", 32'(u_cs_b), 32'd1);
        chk("reset u_rnw", 32'(u_rnw), 32'd1);
        chk("reset u_a0", 32'(u_a0), 32'd0);
        chk("reset u_din", 32'(u_din), 32'd0);
        chk("reset mem_we", 32'(mem_we), 32'd0);
        chk("reset mem_addr", 32'(mem_addr), 32'd0);
        chk("reset mem_wdata", 32'(mem_wdata), 32'd0);
        chk("reset busy/done/error", {29'd0, busy, done, error}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            q.delete();
            for (int k = 0; k < tbl[i].n; k++) q.push_back(tbl[i].bytes[8*k +: 8]);
            w0 = wr_log.size(); t0 = tx_log.size();
            run_frame(tbl[i].name, q, tbl[i].hold, i);
            chk({tbl[i].name, " table writes"}, wr_log.size() - w0, tbl[i].nwr);
            chk({tbl[i].name, " table first write"}, 32'(wr_log[w0]), 32'(tbl[i].first_wr));
            chk({tbl[i].name, " table reply"}, 32'(tx_log[t0]), 32'(tbl[i].reply));
            chk({tbl[i].name, " table error"}, 32'(error), 32'(tbl[i].err));
        end

        // Address wrap with a zero length field (256 bytes)
        q.delete();
        q.push_back(8'h55); q.push_back(8'hFF); q.push_back(8'hF0); q.push_back(8'h00);
        s = 32'h1EF;
        for (int k = 0; k < 256; k++) begin
            v = 8'($urandom_range(0, 255));
            q.push_back(v);
            s += v;
        end
        q.push_back(8'(256 - (s % 256)));
        w0 = wr_log.size();
        run_frame("wrap", q, 0, 0);
        chk("wrap first addr", 32'(wr_log[w0][23:8]), 32'hFFF0);
        chk("wrap after FFFF", 32'(wr_log[w0+16][23:8]), 32'h0000);
        chk("wrap last addr", 32'(wr_log[w0+255][23:8]), 32'h00EF);

        // Randomized frames
        for (int r = 0; r < 20; r++) begin
            q.delete();
            repeat ($urandom_range(0, 2)) begin
                v = 8'($urandom_range(0, 255));
                if (v == 8'h55) v = 8'h54;
                q.push_back(v);
            end
            ah = 8'($urandom_range(0, 255));
            al = 8'($urandom_range(0, 255));
            len = 8'($urandom_range(1, 8));
            q.push_back(8'h55); q.push_back(ah); q.push_back(al); q.push_back(len);
            s = int'(ah) + int'(al) + int'(len);
            for (int k = 0; k < int'(len); k++) begin
                v = 8'($urandom_range(0, 255));
                q.push_back(v);
                s += v;
            end
            c = 8'(256 - (s % 256));
            if ($urandom_range(0, 3) == 0) c = c + 8'($urandom_range(1, 255));
            q.push_back(c);
            run_frame("random", q, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 20)) : 0,
                      int'($urandom_range(0, 4)));
        end

        // Reset in the middle of the data field, then a clean frame
        q.delete();
        q.push_back(8'h55); q.push_back(8'h20); q.push_back(8'h00); q.push_back(8'h08);
        for (int k = 0; k < 9; k++) q.push_back(8'(k + 1));
        hold_cfg = 0; gap_cfg = 2;
        w0 = wr_log.size(); t0 = tx_log.size();
        foreach (q[k]) rx_q.push_back(q[k]);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int w = 0; w < 5000 && (wr_log.size() - w0) < 3; w++) @(negedge clk);
        chk("mid-data writes reached", 32'(wr_log.size() - w0 >= 3), 32'd1);
        ws = wr_log.size();
        reset = 1'b1;
        @(negedge clk);
        chk("after reset u_cs_b", 32'(u_cs_b), 32'd1);
        chk("after reset mem_we", 32'(mem_we), 32'd0);
        chk("after reset busy", 32'(busy), 32'd0);
        chk("no access during reset", reset_leak, 0);
        chk("no write during reset", wr_log.size() - ws, 0);
        chk("no reply for aborted frame", tx_log.size() - t0, 0);
        reset = 1'b0;
        @(negedge clk);
        q.delete();
        for (int k = 0; k < 7; k++) q.push_back(tbl[0].bytes[8*k +: 8]);
        run_frame("after reset", q, 0, 1);

`ifdef LOADER_TIMEOUT_EN
        begin
            logic got_done;
            int   done_cyc;
            q.delete();
            q.push_back(8'h55); q.push_back(8'h12); q.push_back(8'h34); q.push_back(8'h04);
            hold_cfg = 0; gap_cfg = 0;
            w0 = wr_log.size(); t0 = tx_log.size();
            foreach (q[k]) rx_q.push_back(q[k]);
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
            got_done = 1'b0;
            done_cyc = 0;
            for (int w = 0; w < 2000 && !got_done; w++) begin
                @(negedge clk);
                got_done = done;
                done_cyc = cyc;
            end
            chk("timeout done", 32'(got_done), 32'd1);
            chk("timeout reply", 32'(tx_log[t0]), 32'h15);
            chk("timeout error", 32'(error), 32'd1);
            chk("timeout no writes", wr_log.size() - w0, 0);
            chk("timeout latency", 32'((done_cyc - last_rd_cyc) >= 100 &&
                                       (done_cyc - last_rd_cyc) <= 120), 32'd1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_loader.md
Name: uart_loader

Overview:
- Bus initiator that drives the CPU-side register interface of the team's memory-mapped UART peripheral (status at a0=0, data at a0=1), in place of a CPU.
- After a start pulse it polls the UART status, receives one framed download (sync, address, length, data, checksum) and writes each data byte to a byte-wide memory port.
- Returns a one-byte ACK/NAK through the UART transmitter.
- Used as a serial boot/download engine that fills RAM before the CPU is released from reset.

Parameters:
- SYNC_BYTE, 8'h55, frame start marker.
- ACK_BYTE, 8'h06, sent after a good checksum.
- NAK_BYTE, 8'h15, sent after a bad checksum or a timeout.
- TIMEOUT_CYCLES, 3200000, inter-byte timeout in clk cycles (used only with LOADER_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, shared with the UART.
- reset  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins a download. Ignored while busy=1.
- u_dout  in  8  UART read data, combinational. Status byte: bit7 tx_busy, bit6 rx_full, bits5:0 ignored.
- u_din  out  8  UART write data.
- u_a0  out  1  UART register select.
- u_rnw  out  1  UART read(1)/write(0).
- u_cs_b  out  1  UART select, active low.
- mem_addr  out  16  memory write address.
- mem_wdata  out  8  memory write data.
- mem_we  out  1  memory write strobe, one cycle per byte.
- busy  out  1  high from the cycle after start until the cycle after the reply write.
- done  out  1  one-cycle pulse when the reply byte has been written to the UART.
- error  out  1  set on NAK; held until the next accepted start or reset.

Behaviour:
- Reset values: u_cs_b=1, u_rnw=1, u_a0=0, u_din=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0. State=IDLE.
- UART access: u_cs_b is low for exactly one cycle per access and never in two consecutive cycles.
  - Reads sample u_dout in the same cycle u_cs_b is low.
  - Writes present u_din with u_rnw=0 and u_a0=1 in that same cycle.
- States: IDLE, POLL_RX, READ_RX, PARSE, POLL_TX, WRITE_TX, FINISH.
- IDLE: on start, go to POLL_RX, field=SYNC, running sum=0, error cleared.
- POLL_RX: status read (a0=0, rnw=1) on alternate cycles, bus idle in between.
  - Status bit6=1 -> READ_RX next cycle.
- READ_RX: data read (a0=1, rnw=1); byte captured; -> PARSE. The UART clears rx_full on this edge.
- PARSE: one cycle, then POLL_RX unless the frame is complete. Action depends on field:
  - SYNC: byte==SYNC_BYTE -> field AH; any other byte is discarded silently.
  - AH: store high address byte; add to sum; -> AL.
  - AL: store low address byte; add to sum; -> LEN.
  - LEN: store count; 0 means 256; add to sum; -> DATA.
  - DATA: mem_we=1 for one cycle with mem_addr=base+index (16-bit wrap, FFFF->0000) and mem_wdata=byte; add to sum; after the last byte -> CHK.
  - CHK: (sum+byte) mod 256==0 -> reply ACK_BYTE; else reply NAK_BYTE and set error. -> POLL_TX.
- Data is written to memory as received, unbuffered. A bad checksum does not undo memory writes.
- POLL_TX: status read on alternate cycles; bit7=0 -> WRITE_TX.
- WRITE_TX: one write of the reply byte; -> FINISH.
- FINISH: done=1 for one cycle, busy=0; -> IDLE.
- Exactly one reply write per frame, and never while the last polled tx_busy=1.
- Reset in any state returns to reset values on the next edge. No partial memory or UART access completes after reset is asserted.
- The sum is 8-bit modulo and covers AH..last data byte. SYNC is excluded.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined:
  - A counter reloads on every READ_RX and counts during POLL_RX while field!=SYNC.
  - Reaching TIMEOUT_CYCLES aborts the frame: error=1, NAK_BYTE sent via POLL_TX/WRITE_TX, then done.
  - No timeout applies while waiting for SYNC.
- Undefined: no counter exists; the loader waits indefinitely for each byte.

Test Plan:
- Good frame: bytes 55 12 34 02 AA BB 53 -> mem writes 1234<=AA, 1235<=BB; one UART write of 06; done pulse; error=0.
- Bad checksum: same frame with last byte 54 -> same two mem writes; one UART write of 15; error=1 until next start.
- Noise before sync: 00 FF 13 55 12 34 01 77 42 -> no writes for the first three bytes; 1234<=77; reply 06.
- Wrap and length 0: header 55 FF F0 00 plus 256 data bytes and a correct checksum -> 256 writes, FFF0..FFFF then 0000..00EF; reply 06.
- Backpressure: model holds tx_busy=1 for 50 cycles at reply time -> status polls only, no write while busy; exactly one write of 06 after release.
- Reset mid-DATA, then a good frame: u_cs_b=1, mem_we=0, busy=0 on the cycle after reset; the new frame completes normally. With LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=100, stop after LEN -> NAK 15 and error=1 after 100 idle cycles.
